// File: rtl/pq_client_arbiter.sv
// pq_client_arbiter
//   Shares one systolic min-priority queue between NUM_CLIENTS requesters using
//   round-robin arbitration. One queue operation is issued per grant, then the
//   arbiter idles for SETTLE_CYCLES so the next operation sees a sorted head.
//
// Ports
//   CLK, RSTn              clock, asynchronous active-low reset
//   req_valid/op/data      per-client request (op: 01 enq, 10 deq, 11 replace)
//   req_ready              one-hot accept pulse (combinational, IDLE only)
//   rsp_valid/rsp_data     one-hot response pulse with the dequeued head
//   pq_wrt/pq_read/pq_data registered strobes and key to the queue
//   pq_full/pq_empty/pq_head status and head value from the queue
//
// Optional feature: define PQ_ARB_STATS_EN to add stat_ops/stat_stalls counters.
module pq_client_arbiter #(
  parameter int unsigned NUM_CLIENTS   = 4,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                              CLK,
  input  logic                              RSTn,
  input  logic [NUM_CLIENTS-1:0]            req_valid,
  input  logic [2*NUM_CLIENTS-1:0]          req_op,
  input  logic [DATA_WIDTH*NUM_CLIENTS-1:0] req_data,
  output logic [NUM_CLIENTS-1:0]            req_ready,
  output logic [NUM_CLIENTS-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]             rsp_data,
  output logic                              pq_wrt,
  output logic                              pq_read,
  output logic [DATA_WIDTH-1:0]             pq_data,
`ifdef PQ_ARB_STATS_EN
  output logic [31:0]                       stat_ops,
  output logic [31:0]                       stat_stalls,
`endif
  input  logic                              pq_full,
  input  logic                              pq_empty,
  input  logic [DATA_WIDTH-1:0]             pq_head
);

  localparam int unsigned PtrW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StIssue  = 2'd1;
  localparam logic [1:0] StSettle = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [PtrW-1:0]       rr_q, rr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [1:0]            op_q, op_d;
  logic [PtrW-1:0]       win_q, win_d;
  logic                  pq_wrt_q, pq_wrt_d;
  logic                  pq_read_q, pq_read_d;
  logic [DATA_WIDTH-1:0] pq_data_q, pq_data_d;
  logic [NUM_CLIENTS-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic [1:0]            op_arr   [NUM_CLIENTS];
  logic [DATA_WIDTH-1:0] data_arr [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0] elig;
  logic                  any_elig;
  logic [PtrW-1:0]       win;
  int unsigned           idx;
  logic                  grant;

  // Per-client eligibility; ineligible requests simply wait.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      op_arr[i]   = req_op[2*i +: 2];
      data_arr[i] = req_data[DATA_WIDTH*i +: DATA_WIDTH];
      case (req_op[2*i +: 2])
        2'b01:   elig[i] = req_valid[i] & ~pq_full;
        2'b10:   elig[i] = req_valid[i] & ~pq_empty;
        2'b11:   elig[i] = req_valid[i];
        default: elig[i] = 1'b0;
      endcase
    end
  end

  // Scan downwards so the last hit is the first eligible index at/after rr_q.
  always_comb begin
    any_elig = 1'b0;
    win      = '0;
    idx      = 0;
    for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
      idx = (32'(rr_q) + 32'(k)) % NUM_CLIENTS;
      if (elig[idx[PtrW-1:0]]) begin
        any_elig = 1'b1;
        win      = idx[PtrW-1:0];
      end
    end
  end

  assign grant = (state_q == StIdle) && any_elig;

  always_comb begin
    req_ready = '0;
    if (grant && RSTn) req_ready[win] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    win_d       = win_q;
    pq_wrt_d    = 1'b0;
    pq_read_d   = 1'b0;
    pq_data_d   = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      StIdle: begin
        if (any_elig) begin
          op_d      = op_arr[win];
          win_d     = win;
          pq_wrt_d  = op_arr[win][0];
          pq_read_d = op_arr[win][1];
          pq_data_d = data_arr[win];
          rr_d      = (32'(win) == NUM_CLIENTS - 1) ? '0 : win + 1'b1;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        // Head is captured before the queue reacts to this cycle's strobe.
        if (op_q[1]) begin
          rsp_valid_d[win_q] = 1'b1;
          rsp_data_d         = (op_q[0] && pq_empty) ? '1 : pq_head;
        end
        cnt_d   = CntW'(SETTLE_CYCLES - 1);
        state_d = StSettle;
      end
      StSettle: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= StIdle;
      rr_q        <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      win_q       <= '0;
      pq_wrt_q    <= 1'b0;
      pq_read_q   <= 1'b0;
      pq_data_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      win_q       <= win_d;
      pq_wrt_q    <= pq_wrt_d;
      pq_read_q   <= pq_read_d;
      pq_data_q   <= pq_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign pq_wrt    = pq_wrt_q;
  assign pq_read   = pq_read_q;
  assign pq_data   = pq_data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

`ifdef PQ_ARB_STATS_EN
  logic [31:0] stat_ops_q, stat_ops_d;
  logic [31:0] stat_stalls_q, stat_stalls_d;

  always_comb begin
    stat_ops_d    = stat_ops_q;
    stat_stalls_d = stat_stalls_q;
    if (state_q == StIssue && stat_ops_q != '1) stat_ops_d = stat_ops_q + 32'd1;
    if (state_q == StIdle && (|req_valid) && !any_elig && stat_stalls_q != '1) begin
      stat_stalls_d = stat_stalls_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      stat_ops_q    <= '0;
      stat_stalls_q <= '0;
    end else begin
      stat_ops_q    <= stat_ops_d;
      stat_stalls_q <= stat_stalls_d;
    end
  end

  assign stat_ops    = stat_ops_q;
  assign stat_stalls = stat_stalls_q;
`endif

endmodule
